genius_input_checker: RTL

GENIUS_INPUT_CHECKER -- requirements
Module: genius_input_checker

---
 rtl/genius_input_checker.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/genius_input_checker.sv
// Checks a player's button presses against a stored sequence of up to 16 two-bit symbols.
// Define GENIUS_TIMEOUT_EN to fail a round when no press arrives within TIMEOUT_CYCLES cycles.
module genius_input_checker #(
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        bt0,
  input  logic        bt1,
  input  logic        bt2,
  input  logic        start,
  input  logic [4:0]  length,
  input  logic [31:0] seq_flat,
  output logic        busy,
  output logic [3:0]  idx,
  output logic        btn_valid,
  output logic [1:0]  btn_code,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        fail_timeout
);

  typedef enum logic [2:0] {IDLE, WAIT_PRESS, WAIT_RELEASE, PASS, FAIL} state_t;

  state_t      state, next_state;
  logic [2:0]  sync1, sync2, prev;
  logic [2:0]  rise;
  logic [31:0] seq_q, next_seq;
  logic [4:0]  len_q, next_len;
  logic [3:0]  next_idx;
  logic        next_btn_valid, next_done, next_pass, next_fail;
  logic [1:0]  next_btn_code;
  logic [1:0]  press_code;
  logic [1:0]  expected;
  logic        single_press, multi_press;
  logic        timeout_hit;

  // Two-flop synchronizer followed by a one-cycle delayed copy for edge detection
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= {bt2, bt1, bt0};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise        = sync2 & ~prev;
  assign multi_press = (rise[0] & rise[1]) | (rise[0] & rise[2]) | (rise[1] & rise[2]);
  assign expected    = seq_q[{idx, 1'b0} +: 2];
  assign busy        = (state != IDLE);

  always_comb begin
    single_press = 1'b1;
    press_code   = 2'd0;
    case (rise)
      3'b001:  press_code = 2'd0;
      3'b010:  press_code = 2'd1;
      3'b100:  press_code = 2'd2;
      default: single_press = 1'b0;
    endcase
  end

`ifdef GENIUS_TIMEOUT_EN
  localparam logic [25:0] TMO_LAST = 26'(TIMEOUT_CYCLES - 1);

  logic [25:0] tmo_cnt, next_tmo_cnt;
  logic        fail_timeout_q;

  assign timeout_hit  = (tmo_cnt == TMO_LAST);
  assign fail_timeout = fail_timeout_q;

  // Counter restarts whenever WAIT_PRESS is entered from another state
  always_comb begin
    next_tmo_cnt = tmo_cnt;
    if (state == WAIT_PRESS)
      next_tmo_cnt = tmo_cnt + 26'd1;
    if (next_state == WAIT_PRESS && state != WAIT_PRESS)
      next_tmo_cnt = '0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tmo_cnt        <= '0;
      fail_timeout_q <= 1'b0;
    end else begin
      tmo_cnt <= next_tmo_cnt;
      if (state == IDLE && start)
        fail_timeout_q <= 1'b0;
      else if (state == WAIT_PRESS && rise == 3'b000 && timeout_hit)
        fail_timeout_q <= 1'b1;
    end
  end
`else
  assign timeout_hit  = 1'b0;
  assign fail_timeout = 1'b0;
`endif

  always_comb begin
    next_state     = state;
    next_seq       = seq_q;
    next_len       = len_q;
    next_idx       = idx;
    next_btn_valid = 1'b0;
    next_btn_code  = btn_code;
    next_done      = 1'b0;
    next_pass      = pass;
    next_fail      = fail;
    case (state)
      IDLE: begin
        if (start) begin
          next_seq   = seq_flat;
          next_len   = (length > 5'd16) ? 5'd16 : length;
          next_idx   = 4'd0;
          next_pass  = 1'b0;
          next_fail  = 1'b0;
          next_state = (length == 5'd0) ? PASS : WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        if (multi_press) begin
          next_state = FAIL;
        end else if (single_press) begin
          next_btn_valid = 1'b1;
          next_btn_code  = press_code;
          next_state     = (press_code == expected) ? WAIT_RELEASE : FAIL;
        end else if (timeout_hit) begin
          next_state = FAIL;
        end
      end
      WAIT_RELEASE: begin
        if (sync2 == 3'b000) begin
          if ({1'b0, idx} == len_q - 5'd1 || idx == 4'd15) begin
            next_state = PASS;
          end else begin
            next_idx   = idx + 4'd1;
            next_state = WAIT_PRESS;
          end
        end
      end
      PASS: begin
        next_done  = 1'b1;
        next_pass  = 1'b1;
        next_state = IDLE;
      end
      FAIL: begin
        next_done  = 1'b1;
        next_fail  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      seq_q     <= '0;
      len_q     <= '0;
      idx       <= '0;
      btn_valid <= 1'b0;
      btn_code  <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= next_state;
      seq_q     <= next_seq;
      len_q     <= next_len;
      idx       <= next_idx;
      btn_valid <= next_btn_valid;
      btn_code  <= next_btn_code;
      done      <= next_done;
      pass      <= next_pass;
      fail      <= next_fail;
    end
  end

endmodule
